nios2_debug_slave_sysclk_mc: RTL and testbench



---
 rtl/nios2_debug_slave_sysclk_mc_pkg.sv | 19 +
 rtl/nios2_debug_slave_sysclk_mc_if.sv | 25 ++
 rtl/nios2_debug_slave_sysclk_mc_sync_edge.sv | 42 ++++
 rtl/nios2_debug_slave_sysclk_mc.sv | 173 +++++++++++++++++
 tb/tb_nios2_debug_slave_sysclk_mc.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/nios2_debug_slave_sysclk_mc_pkg.sv
// Shared types and helpers for the sysclk-side debug slave.
// Pure declarations: no latency and no backpressure.
package nios2_dbg_slave_pkg;

  localparam int ACT_BIT_DEF = 34;
  localparam int SR_W_DEF    = 38;
  localparam int IR_W_DEF    = 2;

  // Command layout at the default widths; the top builds the same layout from its own parameters.
  typedef struct packed {
    logic [IR_W_DEF-1:0] ch;
    logic [SR_W_DEF-1:0] data;
  } cmd_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nios2_debug_slave_sysclk_mc_if.sv
// Command-head bundle from the debug slave to the OCI consumers.
// The master drives the head; the slave returns cmd_ready as its backpressure.
interface nios2_debug_slave_sysclk_mc_if #(
  parameter int IR_W   = 2,
  parameter int SR_W   = 38,
  parameter int NUM_CH = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ch;
  logic              cmd_take;
  logic [SR_W-1:0]   jdo;
  logic [NUM_CH-1:0] take_action;
  logic [NUM_CH-1:0] take_no_action;

  modport master (
    output cmd_valid, cmd_ch, cmd_take, jdo, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_take, jdo, take_action, take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/nios2_debug_slave_sysclk_mc_sync_edge.sv
// Synchronises an asynchronous strobe level and emits a registered one-cycle rising-edge event.
// The event appears SYNC_STAGES+1 clk after the input rises; there is no backpressure.
module nios2_dbg_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_evt
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_N = CW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_evt;
  logic [CW-1:0]          r_arm_cnt;
  logic                   w_armed;

  // Until armed, r_prev still follows the level so a strobe held across reset release is absorbed.
  assign w_armed = (r_arm_cnt == ARM_N);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_evt     <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_evt  <= w_armed & r_sync[SYNC_STAGES-1] & ~r_prev;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + CW'(1);
      end
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/nios2_debug_slave_sysclk_mc.sv
// Sysclk half of the debug slave: queues update-DR captures and presents them via valid/ready (vs_udr rise to cmd_valid = SYNC_STAGES+3 clk).
// A full queue drops new commands and sets sticky ovf; optional sr parity check under NIOS2_DBG_SLAVE_PARITY_EN.
module nios2_debug_slave_sysclk_mc
  import nios2_dbg_slave_pkg::*;
#(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int NUM_CH      = 4,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int Q_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vs_uir,
  input  logic                       vs_udr,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  nios2_debug_slave_sysclk_mc_if.master cmd,
  output logic [lvl_w(Q_DEPTH)-1:0]  q_level,
  output logic                       ovf,
  input  logic                       ovf_clr
`ifdef NIOS2_DBG_SLAVE_PARITY_EN
  ,
  output logic                       perr
`endif
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int LVL_W = lvl_w(Q_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(Q_DEPTH);

  typedef struct packed {
    logic [IR_W-1:0] ch;
    logic [SR_W-1:0] data;
  } q_ent_t;

  logic              w_uir_evt;
  logic              w_udr_evt;
  logic              w_sr_ok;
  logic [SR_W-1:0]   w_sr_dat;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_valid;
  logic              w_pop;
  q_ent_t            w_head;
  logic [NUM_CH-1:0] w_act;
  logic [NUM_CH-1:0] w_nact;

  logic [IR_W-1:0]   r_ir;
  logic              r_push_vld;
  q_ent_t            r_push_dat;
  q_ent_t            r_mem [Q_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_count;
  logic              r_ovf;

  nios2_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (vs_uir),
    .o_evt   (w_uir_evt)
  );

  nios2_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (vs_udr),
    .o_evt   (w_udr_evt)
  );

`ifdef NIOS2_DBG_SLAVE_PARITY_EN
  // MSB is odd parity over the rest, so a good word XORs to 1; the parity bit is not forwarded.
  assign w_sr_ok  = ^sr;
  assign w_sr_dat = {1'b0, sr[SR_W-2:0]};
`else
  assign w_sr_ok  = 1'b1;
  assign w_sr_dat = sr;
`endif

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign w_full  = (r_count == FULL_LVL);
  assign w_push  = r_push_vld & ~w_full;
  assign w_drop  = r_push_vld & w_full;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & cmd.cmd_ready;

  // Push stage samples r_ir before a simultaneous uir update lands, so that command keeps the old channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir       <= '0;
      r_push_vld <= 1'b0;
      r_push_dat <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_uir_evt) begin
        r_ir <= ir_in;
      end
      r_push_vld <= w_udr_evt & w_sr_ok;
      if (w_udr_evt) begin
        r_push_dat <= '{ch: r_ir, data: w_sr_dat};
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_push_dat;
    end
  end

`ifdef NIOS2_DBG_SLAVE_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else if (w_udr_evt && !w_sr_ok) begin
      r_perr <= 1'b1;
    end else if (ovf_clr) begin
      r_perr <= 1'b0;
    end
  end

  assign perr = r_perr;
`endif

  assign w_head = r_mem[r_rd_ptr];

  // Channels at or above NUM_CH still flow through the queue but raise no strobe.
  always_comb begin
    w_act  = '0;
    w_nact = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_valid && (w_head.ch == IR_W'(i))) begin
        w_act[i]  = w_head.data[ACT_BIT];
        w_nact[i] = ~w_head.data[ACT_BIT];
      end
    end
  end

  assign cmd.cmd_valid      = w_valid;
  assign cmd.cmd_ch         = w_valid ? w_head.ch : '0;
  assign cmd.cmd_take       = w_valid & w_head.data[ACT_BIT];
  assign cmd.jdo            = w_valid ? w_head.data : '0;
  assign cmd.take_action    = w_act;
  assign cmd.take_no_action = w_nact;

  assign q_level = r_count;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_nios2_debug_slave_sysclk_mc.sv
// Directed bench for nios2_debug_slave_sysclk_mc: a 4-channel and a 3-channel instance share one stimulus.
module tb_nios2_debug_slave_sysclk_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        vs_uir;
  logic        vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        ovf_clr;
  logic [2:0]  q4;
  logic [2:0]  q3;
  logic        ovf4;
  logic        ovf3;

  int checks   = 0;
  int failures = 0;

  nios2_debug_slave_sysclk_mc_if #(.IR_W(2), .SR_W(38), .NUM_CH(4)) c4 ();
  nios2_debug_slave_sysclk_mc_if #(.IR_W(2), .SR_W(38), .NUM_CH(3)) c3 ();

  nios2_debug_slave_sysclk_mc #(.NUM_CH(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .vs_uir  (vs_uir),
    .vs_udr  (vs_udr),
    .ir_in   (ir_in),
    .sr      (sr),
    .cmd     (c4),
    .q_level (q4),
    .ovf     (ovf4),
    .ovf_clr (ovf_clr)
  );

  nios2_debug_slave_sysclk_mc #(.NUM_CH(3)) dut3 (
    .clk     (clk),
    .reset   (reset),
    .vs_uir  (vs_uir),
    .vs_udr  (vs_udr),
    .ir_in   (ir_in),
    .sr      (sr),
    .cmd     (c3),
    .q_level (q3),
    .ovf     (ovf3),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic udr_pulse(input logic [37:0] v);
    sr     = v;
    vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    tick(4);
  endtask

  task automatic uir_pulse(input logic [1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    tick(4);
  endtask

  task automatic pop_one();
    c4.cmd_ready = 1'b1;
    c3.cmd_ready = 1'b1;
    tick(1);
    c4.cmd_ready = 1'b0;
    c3.cmd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;
    reset        = 1'b1;
    vs_uir       = 1'b0;
    vs_udr       = 1'b1;
    ir_in        = 2'd0;
    sr           = '0;
    ovf_clr      = 1'b0;
    c4.cmd_ready = 1'b0;
    c3.cmd_ready = 1'b0;
    tick(3);

    check("rst_valid", 64'(c4.cmd_valid), 64'd0);
    check("rst_qlvl", 64'(q4), 64'd0);
    check("rst_ovf", 64'(ovf4), 64'd0);
    check("rst_jdo", 64'(c4.jdo), 64'd0);
    check("rst_act", 64'(c4.take_action), 64'd0);

    // vs_udr held high through reset release must not create a command.
    reset = 1'b0;
    bad   = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (q4 != 3'd0 || q3 != 3'd0 || c4.cmd_valid) bad++;
    end
    check("held_udr_no_push", 64'(bad), 64'd0);
    vs_udr = 1'b0;
    tick(4);
    check("held_udr_qlvl", 64'(q4), 64'd0);

    uir_pulse(2'd2);

    sr     = 38'h4_0000_0ABC;
    vs_udr = 1'b1;
    lat    = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (c4.cmd_valid && lat == 0) lat = k;
    end
    vs_udr = 1'b0;
    tick(3);
    check("latency", 64'(lat), 64'd5);
    check("act4", 64'(c4.take_action), 64'h4);
    check("nact4", 64'(c4.take_no_action), 64'h0);
    check("jdo", 64'(c4.jdo), 64'h4_0000_0ABC);
    check("ch", 64'(c4.cmd_ch), 64'd2);
    check("take", 64'(c4.cmd_take), 64'd1);
    check("act3", 64'(c3.take_action), 64'h4);
    pop_one();
    check("pop_qlvl", 64'(q4), 64'd0);
    check("pop_valid", 64'(c4.cmd_valid), 64'd0);

    for (int i = 1; i <= 5; i++) udr_pulse(38'(i));
    check("ovf_qlvl", 64'(q4), 64'd4);
    check("ovf_set", 64'(ovf4), 64'd1);
    check("ovf_head", 64'(c4.jdo), 64'd1);
    check("ovf_ch", 64'(c4.cmd_ch), 64'd2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 64'(ovf4), 64'd0);
    check("ovf_clr_qlvl", 64'(q4), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_jdo%0d", i), 64'(c4.jdo), 64'(i));
      check($sformatf("drain_nact%0d", i), 64'(c4.take_no_action), 64'h4);
      pop_one();
    end
    check("drain_qlvl", 64'(q4), 64'd0);

    uir_pulse(2'd3);
    ir_in  = 2'd1;
    sr     = 38'h0_0000_0055;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick(4);
    check("simul_ch", 64'(c4.cmd_ch), 64'd3);
    check("simul_take", 64'(c4.cmd_take), 64'd0);
    check("simul_nact4", 64'(c4.take_no_action), 64'h8);
    check("simul_act4", 64'(c4.take_action), 64'h0);
    check("ch3_valid", 64'(c3.cmd_valid), 64'd1);
    check("ch3_act", 64'(c3.take_action), 64'h0);
    check("ch3_nact", 64'(c3.take_no_action), 64'h0);
    check("ch3_jdo", 64'(c3.jdo), 64'h55);
    pop_one();
    check("ch3_pop_qlvl", 64'(q3), 64'd0);
    check("ch3_pop_qlvl4", 64'(q4), 64'd0);

    udr_pulse(38'h4_0000_0077);
    check("next_ch", 64'(c4.cmd_ch), 64'd1);
    check("next_act4", 64'(c4.take_action), 64'h2);
    check("next_act3", 64'(c3.take_action), 64'h2);
    pop_one();
    check("end_qlvl", 64'(q4), 64'd0);
    check("end_ovf", 64'(ovf4), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
